// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with PC, memory handshake and Fetch/Decode register.
// Ports:
//   clk, Reset (async, active-low)
//   StallF, StallD, FlushD      hazard-unit controls
//   BranchTakenE, ALUResultE     branch redirect from Execute
//   PCSrcW, ResultW              PC write from Writeback
//   InstrRdata, InstrReady       instruction memory response for PCF
//   PCF, InstrReq, FetchBusyF    fetch address, request, memory-wait stall
//   InstrD, PCPlus8D, ValidD     Decode pipeline register
//   FetchWaitCnt                 saturating count of memory-wait cycles
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             BranchTakenE,
    input  logic [31:0]      ALUResultE,
    input  logic             PCSrcW,
    input  logic [31:0]      ResultW,
    input  logic [31:0]      InstrRdata,
    input  logic             InstrReady,
    output logic [31:0]      PCF,
    output logic             InstrReq,
    output logic             FetchBusyF,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCPlus8D,
    output logic             ValidD,
    output logic [CNT_W-1:0] FetchWaitCnt
);
    typedef enum logic {BOOT, RUN} state_t;
    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc8_q, pc8_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_done;
    always_comb begin
        state_d = RUN;
        req_d   = (state_d == RUN);
    end
    // req_q mirrors state RUN, so it doubles as the "state is RUN" qualifier
    assign fetch_done = req_q & InstrReady & ~StallF;
    assign FetchBusyF = req_q & ~InstrReady;
    always_comb begin
        // redirects bypass StallF and memory wait; branch beats Writeback
        pc_d    = BranchTakenE ? ALUResultE : PCSrcW ? ResultW : fetch_done ? pc_q + 32'd4 : pc_q;
        instr_d = FlushD ? 32'h0 : StallD ? instr_q : fetch_done ? InstrRdata  : 32'h0;
        pc8_d   = FlushD ? 32'h0 : StallD ? pc8_q   : fetch_done ? pc_q + 32'd8 : 32'h0;
        valid_d = FlushD ? 1'b0  : StallD ? valid_q : fetch_done;
        cnt_d   = (FetchBusyF && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= BOOT;
            req_q   <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc8_q   <= 32'h0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc8_q   <= pc8_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end
    assign PCF          = pc_q;
    assign InstrReq     = req_q;
    assign InstrD       = instr_q;
    assign PCPlus8D     = pc8_q;
    assign ValidD       = valid_q;
    assign FetchWaitCnt = cnt_q;
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU. Holds the program counter, requests instructions from instruction memory with a ready handshake, and selects the next PC (sequential, branch target from Execute, or PC write from Writeback). Drives the Fetch/Decode pipeline register that feeds the decoder and the hazard unit. Obeys StallF/StallD/FlushD from the hazard unit and reports memory-wait stalls back to it.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the fetch-wait performance counter.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- StallF  in  1  hold PCF (hazard unit).
- StallD  in  1  hold the Decode register (hazard unit).
- FlushD  in  1  clear the Decode register to a bubble (hazard unit).
- BranchTakenE  in  1  branch resolved taken in Execute.
- ALUResultE  in  32  branch target from Execute.
- PCSrcW  in  1  instruction in Writeback writes the PC.
- ResultW  in  32  PC value from Writeback.
- InstrRdata  in  32  instruction word for the address on PCF.
- InstrReady  in  1  InstrRdata valid for the current PCF, same cycle.
- PCF  out  32  current fetch address, registered.
- InstrReq  out  1  fetch request, registered from state.
- FetchBusyF  out  1  InstrReq & ~InstrReady, combinational, to the hazard unit.
- InstrD  out  32  instruction in Decode.
- PCPlus8D  out  32  address of the instruction in Decode + 8.
- ValidD  out  1  InstrD holds a real instruction.
- FetchWaitCnt  out  CNT_W  saturating count of FetchBusyF cycles.

## Operation

- FSM states BOOT, RUN.
  - BOOT: entered on reset. InstrReq=0. Moves to RUN on the first clock edge after Reset goes high.
  - RUN: InstrReq=1. Stays in RUN until reset.
- Fetch completes in a cycle when state=RUN, InstrReady=1 and StallF=0.
- Next-PC selection, in priority order:
  - BranchTakenE: ALUResultE.
  - PCSrcW: ResultW.
  - Fetch completes: PCF+4.
  - Otherwise: hold PCF.
- A redirect (BranchTakenE or PCSrcW) overrides StallF and memory wait. PCF loads the target even when StallF=1 or InstrReady=0, and the pending fetch is abandoned.
- All redirects, including in BOOT, go through this selection.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- Decode register, evaluated at each edge in priority order:
  - FlushD: InstrD=0, PCPlus8D=0, ValidD=0.
  - StallD: hold all three.
  - Fetch completes: InstrD=InstrRdata, PCPlus8D=PCF+8, ValidD=1.
  - Otherwise: bubble, with InstrD=0, PCPlus8D=0, ValidD=0.
- The hazard unit already asserts FlushD on BranchTakenE and PCSrcW, so a word completing in a redirect cycle never reaches Decode.
- FetchWaitCnt increments on every cycle where FetchBusyF=1 and holds at all-ones (no wrap).
- In the reset state FetchBusyF=0, because InstrReq=0.

## Timing

- Reset values, applied asynchronously on Reset=0 and held while low:
  - PCF=RESET_PC, InstrReq=0, state=BOOT.
  - InstrD=0, PCPlus8D=0, ValidD=0, FetchWaitCnt=0.
- Reset mid-operation drops any pending fetch and any Decode content immediately, without waiting for a clock edge.
- Latency: a word accepted at edge k appears on InstrD/ValidD after edge k. PCF advances at the same edge.
- With zero-wait memory, throughput is one instruction per cycle.
- Each memory wait cycle inserts one bubble (ValidD=0), unless StallD holds Decode.
- Redirect latency: target is on PCF one edge after BranchTakenE or PCSrcW is sampled. It is fetched in that cycle if InstrReady=1.
- Simultaneous BranchTakenE and PCSrcW: the branch target wins.
- StallF=1 with StallD=0 and no FlushD produces a bubble in Decode.
- FlushD together with StallD: the flush wins.

## Test plan

- Reset release, InstrReady tied 1, RESET_PC=0 -> one BOOT cycle with InstrReq=0. Then PCF=0,4,8 on successive cycles; InstrD follows one cycle later with PCPlus8D=8,12,16 and ValidD=1.
- InstrReady=0 for 3 cycles at PCF=0x10 -> PCF holds 0x10, FetchBusyF=1, three bubbles (ValidD=0), FetchWaitCnt=3. Then the word at 0x10 is accepted.
- BranchTakenE=1 with ALUResultE=0x200, StallF=1 and InstrReady=0 -> PCF=0x200 next cycle. FlushD clears Decode to ValidD=0, InstrD=0.
- BranchTakenE=1 (0x300) and PCSrcW=1 (ResultW=0x400) in the same cycle -> PCF=0x300.
- StallF=StallD=1 for 2 cycles -> PCF, InstrD, PCPlus8D and ValidD all unchanged. Then FlushD=1 with StallD=1 -> ValidD=0.
- Reset asserted mid-stream at PCF=0x40 -> PCF=RESET_PC, ValidD=0, InstrReq=0 before the next edge. Also, with CNT_W=4 and 20 wait cycles, FetchWaitCnt saturates at 15.
